// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, UART
// register offsets and the bus-output decode used by the scheduler FSM.
package uart_tx_sched_pkg;

   typedef enum logic [2:0] {
      ST_CFG     = 3'd0,
      ST_IDLE    = 3'd1,
      ST_RD_CTRL = 3'd2,
      ST_CHK     = 3'd3,
      ST_WR_BUF  = 3'd4
   } state_e;

   localparam logic [7:0] REG_BAUD = 8'd0;
   localparam logic [7:0] REG_CTRL = 8'd1;
   localparam logic [7:0] REG_BUF  = 8'd2;

   localparam int TX_EMPTY_BIT = 1;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       w_en;
      logic       r_en;
   } bus_out_t;

   // Bus outputs are a pure function of the state being entered and the held
   // byte; register addresses wrap modulo 256 through the 8-bit sum.
   function automatic bus_out_t bus_decode(input state_e     st,
                                           input logic [7:0] base,
                                           input logic [7:0] baud,
                                           input logic [7:0] hold);
      bus_out_t o;
      o.addr  = base;
      o.wdata = 8'h00;
      o.w_en  = 1'b0;
      o.r_en  = 1'b0;
      case (st)
         ST_CFG: begin
            o.addr  = base + REG_BAUD;
            o.wdata = baud;
            o.w_en  = 1'b1;
         end
         ST_RD_CTRL: begin
            o.addr = base + REG_CTRL;
            o.r_en = 1'b1;
         end
         ST_WR_BUF: begin
            o.addr  = base + REG_BUF;
            o.wdata = hold;
            o.w_en  = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshakes and UART register bus of the transmit scheduler.
// master = the scheduler, slave = requesters plus UART.
interface uart_tx_sched_if;

   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;

   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_w_en;
   logic       bus_r_en;
   logic [7:0] bus_rdata;
   logic       busy;

   modport master (
      input  req0_valid, req0_data, req1_valid, req1_data, bus_rdata,
      output req0_ready, req1_ready, bus_addr, bus_wdata, bus_w_en, bus_r_en, busy
   );

   modport slave (
      output req0_valid, req0_data, req1_valid, req1_data, bus_rdata,
      input  req0_ready, req1_ready, bus_addr, bus_wdata, bus_w_en, bus_r_en, busy
   );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid wins, a tie goes to the
// requester that was not granted last. Grant is one-hot or zero.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates two byte requesters onto a memory-mapped UART: programs the
// baud divider once, then polls tx_empty and writes one byte at a time.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter logic [7:0] UART_ADDRESS = 8'h00,
   parameter logic [7:0] BAUD_DIV     = 8'd6
) (
   input logic             clk,
   input logic             rst,
   uart_tx_sched_if.master bus
);

   state_e     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic       last_grant_q, last_grant_d;
   logic       cfg_sent_q, cfg_sent_d;
   logic       busy_q, busy_d;
   bus_out_t   bus_out_q, bus_out_d;

   logic [1:0] valid;
   logic [1:0] grant;
   logic [1:0] ready;
   logic       tx_empty;
   logic       unused_rdata;

   assign valid        = {bus.req1_valid, bus.req0_valid};
   assign tx_empty     = bus.bus_rdata[TX_EMPTY_BIT];
   assign unused_rdata = ^{bus.bus_rdata[7:2], bus.bus_rdata[0]};

   rr_arb2 u_arb (
      .valid      (valid),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign ready          = (state_q == ST_IDLE) ? grant : 2'b00;
   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];

   // CFG spends its first cycle after reset arming the registered baud write,
   // so the strobe stays low while reset is held and pulses once on release.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      last_grant_d = last_grant_q;
      cfg_sent_d   = cfg_sent_q;
      case (state_q)
         ST_CFG: begin
            if (!cfg_sent_q) begin
               cfg_sent_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (|grant) begin
               hold_d       = grant[1] ? bus.req1_data : bus.req0_data;
               last_grant_d = grant[1];
               state_d      = ST_RD_CTRL;
            end
         end
         ST_RD_CTRL: state_d = ST_CHK;
         ST_CHK:     state_d = tx_empty ? ST_WR_BUF : ST_RD_CTRL;
         ST_WR_BUF:  state_d = ST_IDLE;
         default:    state_d = ST_CFG;
      endcase
      bus_out_d = bus_decode(state_d, UART_ADDRESS, BAUD_DIV, hold_d);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_CFG;
         hold_q       <= 8'h00;
         last_grant_q <= 1'b1;
         cfg_sent_q   <= 1'b0;
         busy_q       <= 1'b1;
         bus_out_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         last_grant_q <= last_grant_d;
         cfg_sent_q   <= cfg_sent_d;
         busy_q       <= busy_d;
         bus_out_q    <= bus_out_d;
      end
   end

   assign bus.bus_addr  = bus_out_q.addr;
   assign bus.bus_wdata = bus_out_q.wdata;
   assign bus.bus_w_en  = bus_out_q.w_en;
   assign bus.bus_r_en  = bus_out_q.r_en;
   assign bus.busy      = busy_q;

   a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
      !(bus_out_q.w_en && bus_out_q.r_en));

   a_ready_idle: assert property (@(posedge clk) disable iff (rst)
      (state_q != ST_IDLE) |-> (ready == 2'b00));

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: configuration write, single and
// alternating transfers, tx_empty polling, mid-transfer reset, address wrap.
module tb_uart_tx_sched;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   both_strobes;
   int   wrote_3c;

   uart_tx_sched_if bus ();
   uart_tx_sched_if bus_ff ();

   uart_tx_sched #(.UART_ADDRESS(8'h00), .BAUD_DIV(8'd6)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   uart_tx_sched #(.UART_ADDRESS(8'hFF), .BAUD_DIV(8'd6)) u_dut_ff (
      .clk (clk),
      .rst (rst),
      .bus (bus_ff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watches the whole run for overlapping strobes and for the discarded byte.
   always @(negedge clk) begin
      if (bus.bus_w_en && bus.bus_r_en) both_strobes++;
      if (bus.bus_w_en && bus.bus_addr == 8'h02 && bus.bus_wdata == 8'h3C) wrote_3c++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1,
                                input logic [7:0] rdata);
      bus.req0_valid = v0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_data  = d1;
      bus.bus_rdata  = rdata;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_w_en", bus.bus_w_en, 1'b0);
      checkOutput("rst_r_en", bus.bus_r_en, 1'b0);
      checkOutput("rst_busy", bus.busy, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("cfg_w_en", bus.bus_w_en, 1'b1);
      checkOutput("cfg_addr", bus.bus_addr, 8'h00);
      checkOutput("cfg_wdata", bus.bus_wdata, 8'd6);
      tick();
      checkOutput("cfg_done_busy", bus.busy, 1'b0);
      checkOutput("cfg_done_w_en", bus.bus_w_en, 1'b0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      both_strobes = 0;
      wrote_3c     = 0;
      rst          = 1'b1;
      bus_ff.req0_valid = 1'b0;
      bus_ff.req0_data  = 8'h00;
      bus_ff.req1_valid = 1'b0;
      bus_ff.req1_data  = 8'h00;
      bus_ff.bus_rdata  = 8'h00;
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
      tick();
      tick();

      // Reset state, including ready held low while a requester is valid
      checkOutput("reset_w_en", bus.bus_w_en, 1'b0);
      checkOutput("reset_r_en", bus.bus_r_en, 1'b0);
      checkOutput("reset_busy", bus.busy, 1'b1);
      checkOutput("reset_ff_w_en", bus_ff.bus_w_en, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 8'h00);
      checkOutput("reset_ready0", bus.req0_ready, 1'b0);
      checkOutput("reset_ready1", bus.req1_ready, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

      rst = 1'b0;
      tick();
      checkOutput("cfg_w_en", bus.bus_w_en, 1'b1);
      checkOutput("cfg_r_en", bus.bus_r_en, 1'b0);
      checkOutput("cfg_addr", bus.bus_addr, 8'h00);
      checkOutput("cfg_wdata", bus.bus_wdata, 8'd6);
      checkOutput("cfg_busy", bus.busy, 1'b1);
      checkOutput("ff_cfg_addr", bus_ff.bus_addr, 8'hFF);
      checkOutput("ff_cfg_wdata", bus_ff.bus_wdata, 8'd6);
      checkOutput("ff_cfg_w_en", bus_ff.bus_w_en, 1'b1);
      tick();
      checkOutput("idle_w_en", bus.bus_w_en, 1'b0);
      checkOutput("idle_busy", bus.busy, 1'b0);
      checkOutput("idle_addr", bus.bus_addr, 8'h00);
      checkOutput("idle_wdata", bus.bus_wdata, 8'h00);
      checkOutput("ff_idle_busy", bus_ff.busy, 1'b0);

      // Single byte from req0 with the transmitter already empty
      applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 8'h02);
      checkOutput("a_ready0", bus.req0_ready, 1'b1);
      checkOutput("a_ready1", bus.req1_ready, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h02);
      checkOutput("a_rd_r_en", bus.bus_r_en, 1'b1);
      checkOutput("a_rd_addr", bus.bus_addr, 8'h01);
      checkOutput("a_rd_w_en", bus.bus_w_en, 1'b0);
      checkOutput("a_rd_busy", bus.busy, 1'b1);
      tick();
      checkOutput("a_chk_r_en", bus.bus_r_en, 1'b0);
      checkOutput("a_chk_w_en", bus.bus_w_en, 1'b0);
      tick();
      checkOutput("a_wr_w_en", bus.bus_w_en, 1'b1);
      checkOutput("a_wr_addr", bus.bus_addr, 8'h02);
      checkOutput("a_wr_wdata", bus.bus_wdata, 8'hA5);
      tick();
      checkOutput("a_end_busy", bus.busy, 1'b0);
      checkOutput("a_end_w_en", bus.bus_w_en, 1'b0);

      // Fresh reset so both requesters start with req0 favoured
      doReset();
      applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 8'h02);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("b_ready0", bus.req0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
         checkOutput("b_ready1", bus.req1_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
         tick();
         checkOutput("b_rd_r_en", bus.bus_r_en, 1'b1);
         tick();
         tick();
         checkOutput("b_wr_w_en", bus.bus_w_en, 1'b1);
         checkOutput("b_wr_wdata", bus.bus_wdata, (i % 2 == 0) ? 8'h11 : 8'h22);
         tick();
         checkOutput("b_idle_busy", bus.busy, 1'b0);
      end

      // Three not-empty polls, then empty; req0 stays valid but must not see ready
      applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 8'h00);
      checkOutput("c_ready0", bus.req0_ready, 1'b1);
      tick();
      for (int p = 0; p < 4; p++) begin
         checkOutput("c_poll_r_en", bus.bus_r_en, 1'b1);
         checkOutput("c_poll_addr", bus.bus_addr, 8'h01);
         checkOutput("c_poll_w_en", bus.bus_w_en, 1'b0);
         checkOutput("c_poll_ready0", bus.req0_ready, 1'b0);
         bus.bus_rdata = (p == 3) ? 8'h02 : 8'h00;
         tick();
         checkOutput("c_chk_r_en", bus.bus_r_en, 1'b0);
         checkOutput("c_chk_w_en", bus.bus_w_en, 1'b0);
         checkOutput("c_chk_ready0", bus.req0_ready, 1'b0);
         tick();
      end
      checkOutput("c_wr_w_en", bus.bus_w_en, 1'b1);
      checkOutput("c_wr_addr", bus.bus_addr, 8'h02);
      checkOutput("c_wr_wdata", bus.bus_wdata, 8'h5A);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h02);
      tick();
      checkOutput("c_end_busy", bus.busy, 1'b0);

      // A valid withdrawn before the clock edge is ignored
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h99, 8'h02);
      checkOutput("d_ready1", bus.req1_ready, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h02);
      tick();
      checkOutput("d_busy", bus.busy, 1'b0);
      checkOutput("d_r_en", bus.bus_r_en, 1'b0);

      // Reset while 8'h3C waits in CHK
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C, 8'h00);
      checkOutput("e_ready1", bus.req1_ready, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
      checkOutput("e_rd_r_en", bus.bus_r_en, 1'b1);
      tick();
      checkOutput("e_chk_busy", bus.busy, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("e_rst_w_en", bus.bus_w_en, 1'b0);
      checkOutput("e_rst_r_en", bus.bus_r_en, 1'b0);
      checkOutput("e_rst_busy", bus.busy, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h44, 8'h02);
      checkOutput("e_rst_ready1", bus.req1_ready, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 8'h02);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("e_cfg_w_en", bus.bus_w_en, 1'b1);
      checkOutput("e_cfg_addr", bus.bus_addr, 8'h00);
      checkOutput("e_cfg_wdata", bus.bus_wdata, 8'd6);
      tick();
      checkOutput("e_idle_busy", bus.busy, 1'b0);
      tick();
      tick();
      checkOutput("e_quiet_w_en", bus.bus_w_en, 1'b0);
      checkOutput("e_no_3c_write", wrote_3c, 0);

      // Address wrap with base 8'hFF
      bus_ff.bus_rdata  = 8'h02;
      bus_ff.req0_data  = 8'h77;
      bus_ff.req0_valid = 1'b1;
      #1;
      checkOutput("f_ready0", bus_ff.req0_ready, 1'b1);
      tick();
      bus_ff.req0_valid = 1'b0;
      checkOutput("f_rd_addr", bus_ff.bus_addr, 8'h00);
      checkOutput("f_rd_r_en", bus_ff.bus_r_en, 1'b1);
      tick();
      tick();
      checkOutput("f_wr_addr", bus_ff.bus_addr, 8'h01);
      checkOutput("f_wr_wdata", bus_ff.bus_wdata, 8'h77);
      checkOutput("f_wr_w_en", bus_ff.bus_w_en, 1'b1);
      tick();
      checkOutput("f_end_busy", bus_ff.busy, 1'b0);

      checkOutput("strobe_overlap", both_strobes, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
